pacman_motion: RTL and testbench

- Computes Pac-Man's sprite position once per video frame and drives `pacman_x`/`pacman_y` into the color mapper.
- Reads the player's requested direction from the keyboard keycode.
- Checks candidate tiles against the wall map through a one-cycle-latency query port.
- Emits a one-cycle "eat" strobe with tile coordinates each time Pac-Man lands exactly on a tile, for the pellet store.

---
 rtl/pacman_pkg.sv | 36 +++
 rtl/frame_tick_gen.sv | 34 +++
 rtl/pacman_motion.sv | 235 +++++++++++++++++++++++
 tb/tb_pacman_motion.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man motion, pellet and ghost stages.
// Directions follow the cur_dir encoding: 0 up, 1 right, 2 down, 3 left.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef struct packed {
    logic       ok;
    logic [5:0] tx;
    logic [4:0] ty;
  } tile_ref_t;

  localparam int TILE_SHIFT = 4;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_RIGHT: r = DIR_LEFT;
      DIR_DOWN:  r = DIR_UP;
      default:   r = DIR_RIGHT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the VGA vsync into the Clk domain and turns each rising edge into a
// single-cycle frame_tick pulse.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign frame_tick = sync2_q & ~prev_q;

endmodule

// File: rtl/pacman_motion.sv
// Per-frame Pac-Man movement: turn/forward wall checks through a one-cycle
// query port, position update, and an eat strobe on each tile arrival.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter int START_TX  = 19,
  parameter int START_TY  = 23,
  parameter int TILE_COLS = 40,
  parameter int TILE_ROWS = 30,
  parameter int STEP      = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [5:0] query_tx,
  output logic [4:0] query_ty,
  input  logic       query_is_wall,
  output logic [9:0] pacman_x,
  output logic [9:0] pacman_y,
  output logic [1:0] cur_dir,
  output logic       moving,
  output logic       eat_valid,
  output logic [5:0] eat_tx,
  output logic [4:0] eat_ty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN_Q,
    S_TURN_W,
    S_FWD_Q,
    S_FWD_W,
    S_MOVE
  } state_t;

  localparam logic [9:0] START_X = 10'(START_TX * 16);
  localparam logic [9:0] START_Y = 10'(START_TY * 16);
  localparam logic [9:0] STEP_PX = 10'(STEP);

  state_t     state_q, state_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  dir_t       cur_dir_q, cur_dir_d;
  logic       moving_q, moving_d;
  logic       eat_valid_q, eat_valid_d;
  logic [5:0] eat_tx_q, eat_tx_d;
  logic [4:0] eat_ty_q, eat_ty_d;
  logic [5:0] query_tx_q, query_tx_d;
  logic [4:0] query_ty_q, query_ty_d;
  dir_t       req_dir_q, req_dir_d;
  logic       req_dir_valid_q, req_dir_valid_d;
  dir_t       frame_req_q, frame_req_d;
  logic       frame_req_valid_q, frame_req_valid_d;

  logic       frame_tick;
  logic       aligned;
  logic [5:0] tile_x;
  logic [4:0] tile_y;
  tile_ref_t  turn_nb;
  tile_ref_t  fwd_nb;
  logic [9:0] next_x;
  logic [9:0] next_y;

  frame_tick_gen u_frame_tick_gen (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // Off-grid neighbours come back with ok = 0 so the FSM treats them as walls.
  function automatic tile_ref_t neighbour(input dir_t d, input logic [5:0] tx,
                                          input logic [4:0] ty);
    tile_ref_t r;
    r.ok = 1'b1;
    r.tx = tx;
    r.ty = ty;
    case (d)
      DIR_UP:    if (ty == 5'd0) r.ok = 1'b0; else r.ty = ty - 5'd1;
      DIR_RIGHT: if (int'(tx) >= TILE_COLS - 1) r.ok = 1'b0; else r.tx = tx + 6'd1;
      DIR_DOWN:  if (int'(ty) >= TILE_ROWS - 1) r.ok = 1'b0; else r.ty = ty + 5'd1;
      default:   if (tx == 6'd0) r.ok = 1'b0; else r.tx = tx - 6'd1;
    endcase
    return r;
  endfunction

  assign aligned = (pos_x_q[3:0] == 4'd0) && (pos_y_q[3:0] == 4'd0);
  assign tile_x  = 6'(pos_x_q >> TILE_SHIFT);
  assign tile_y  = 5'(pos_y_q >> TILE_SHIFT);
  assign turn_nb = neighbour(frame_req_q, tile_x, tile_y);
  assign fwd_nb  = neighbour(cur_dir_q, tile_x, tile_y);

  // The request is snapshotted on frame_tick so a key landing mid-frame
  // only takes effect from the following frame.
  always_comb begin
    state_d           = state_q;
    pos_x_d           = pos_x_q;
    pos_y_d           = pos_y_q;
    cur_dir_d         = cur_dir_q;
    moving_d          = moving_q;
    eat_valid_d       = 1'b0;
    eat_tx_d          = eat_tx_q;
    eat_ty_d          = eat_ty_q;
    query_tx_d        = query_tx_q;
    query_ty_d        = query_ty_q;
    req_dir_d         = req_dir_q;
    req_dir_valid_d   = req_dir_valid_q;
    frame_req_d       = frame_req_q;
    frame_req_valid_d = frame_req_valid_q;
    next_x            = pos_x_q;
    next_y            = pos_y_q;

    case (keycode)
      KEY_W:   begin req_dir_d = DIR_UP;    req_dir_valid_d = 1'b1; end
      KEY_D:   begin req_dir_d = DIR_RIGHT; req_dir_valid_d = 1'b1; end
      KEY_S:   begin req_dir_d = DIR_DOWN;  req_dir_valid_d = 1'b1; end
      KEY_A:   begin req_dir_d = DIR_LEFT;  req_dir_valid_d = 1'b1; end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          frame_req_d       = req_dir_q;
          frame_req_valid_d = req_dir_valid_q;
          if (aligned) begin
            state_d = S_TURN_Q;
          end else begin
            if (req_dir_valid_q && (req_dir_q == opposite(cur_dir_q))) begin
              cur_dir_d = req_dir_q;
            end
            state_d = S_MOVE;
          end
        end
      end
      S_TURN_Q: begin
        if (frame_req_valid_q && (frame_req_q != cur_dir_q) && turn_nb.ok) begin
          query_tx_d = turn_nb.tx;
          query_ty_d = turn_nb.ty;
          state_d    = S_TURN_W;
        end else begin
          state_d = S_FWD_Q;
        end
      end
      S_TURN_W: begin
        if (!query_is_wall) begin
          cur_dir_d = frame_req_q;
          moving_d  = 1'b1;
        end
        state_d = S_FWD_Q;
      end
      S_FWD_Q: begin
        if (fwd_nb.ok) begin
          query_tx_d = fwd_nb.tx;
          query_ty_d = fwd_nb.ty;
          state_d    = S_FWD_W;
        end else begin
          moving_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_FWD_W: begin
        moving_d = !query_is_wall;
        state_d  = query_is_wall ? S_IDLE : S_MOVE;
      end
      S_MOVE: begin
        if (moving_q) begin
          case (cur_dir_q)
            DIR_UP:    next_y = pos_y_q - STEP_PX;
            DIR_RIGHT: next_x = pos_x_q + STEP_PX;
            DIR_DOWN:  next_y = pos_y_q + STEP_PX;
            default:   next_x = pos_x_q - STEP_PX;
          endcase
          pos_x_d = next_x;
          pos_y_d = next_y;
          if ((next_x[3:0] == 4'd0) && (next_y[3:0] == 4'd0)) begin
            eat_valid_d = 1'b1;
            eat_tx_d    = 6'(next_x >> TILE_SHIFT);
            eat_ty_d    = 5'(next_y >> TILE_SHIFT);
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q           <= S_IDLE;
      pos_x_q           <= START_X;
      pos_y_q           <= START_Y;
      cur_dir_q         <= DIR_LEFT;
      moving_q          <= 1'b0;
      eat_valid_q       <= 1'b0;
      eat_tx_q          <= 6'd0;
      eat_ty_q          <= 5'd0;
      query_tx_q        <= 6'd0;
      query_ty_q        <= 5'd0;
      req_dir_q         <= DIR_LEFT;
      req_dir_valid_q   <= 1'b0;
      frame_req_q       <= DIR_LEFT;
      frame_req_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      pos_x_q           <= pos_x_d;
      pos_y_q           <= pos_y_d;
      cur_dir_q         <= cur_dir_d;
      moving_q          <= moving_d;
      eat_valid_q       <= eat_valid_d;
      eat_tx_q          <= eat_tx_d;
      eat_ty_q          <= eat_ty_d;
      query_tx_q        <= query_tx_d;
      query_ty_q        <= query_ty_d;
      req_dir_q         <= req_dir_d;
      req_dir_valid_q   <= req_dir_valid_d;
      frame_req_q       <= frame_req_d;
      frame_req_valid_q <= frame_req_valid_d;
    end
  end

  // The query port is presented combinationally so the wall RAM's registered
  // read lands in the immediately following wait state.
  assign query_tx  = query_tx_d;
  assign query_ty  = query_ty_d;
  assign pacman_x  = pos_x_q;
  assign pacman_y  = pos_y_q;
  assign cur_dir   = cur_dir_q;
  assign moving    = moving_q;
  assign eat_valid = eat_valid_q;
  assign eat_tx    = eat_tx_q;
  assign eat_ty    = eat_ty_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Frame-level scoreboard for pacman_motion: a behavioural model predicts each
// frame's outcome, which is queued and compared once the frame has settled.
module tb_pacman_motion;

  typedef struct {
    int x;
    int y;
    int dir;
    int mov;
    int eats;
    int etx;
    int ety;
    int qx;
    int qy;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [5:0] query_tx;
  logic [4:0] query_ty;
  logic       query_is_wall;
  logic [9:0] pacman_x;
  logic [9:0] pacman_y;
  logic [1:0] cur_dir;
  logic       moving;
  logic       eat_valid;
  logic [5:0] eat_tx;
  logic [4:0] eat_ty;

  int   tests;
  int   fails;
  int   eat_total;
  int   last_eat_tx;
  int   last_eat_ty;
  bit   wall [0:29][0:39];
  exp_t sbq[$];

  int m_x, m_y, m_dir, m_mov, m_req, m_reqv, m_qx, m_qy;

  pacman_motion dut (
    .Clk           (clk),
    .Reset         (rst),
    .frame_clk     (frame_clk),
    .keycode       (keycode),
    .query_tx      (query_tx),
    .query_ty      (query_ty),
    .query_is_wall (query_is_wall),
    .pacman_x      (pacman_x),
    .pacman_y      (pacman_y),
    .cur_dir       (cur_dir),
    .moving        (moving),
    .eat_valid     (eat_valid),
    .eat_tx        (eat_tx),
    .eat_ty        (eat_ty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit wall_at(input int tx, input int ty);
    if (tx < 0 || tx > 39 || ty < 0 || ty > 29) return 1'b1;
    return wall[ty][tx];
  endfunction

  // Registered wall lookup: answer is valid one Clk after the query is driven.
  always @(posedge clk) query_is_wall <= wall_at(int'(query_tx), int'(query_ty));

  always @(negedge clk) begin
    if (eat_valid === 1'b1) begin
      eat_total   = eat_total + 1;
      last_eat_tx = int'(eat_tx);
      last_eat_ty = int'(eat_ty);
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int expv);
    tests = tests + 1;
    if (obs !== expv) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit nbr(input int d, input int tx, input int ty,
                             output int nx, output int ny);
    nx = tx;
    ny = ty;
    case (d)
      0:       ny = ty - 1;
      1:       nx = tx + 1;
      2:       ny = ty + 1;
      default: nx = tx - 1;
    endcase
    return (nx >= 0 && nx < 40 && ny >= 0 && ny < 30);
  endfunction

  function automatic int key_dir(input logic [7:0] k);
    case (k)
      8'h1A:   return 0;
      8'h07:   return 1;
      8'h16:   return 2;
      8'h04:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 304; m_y = 368; m_dir = 3; m_mov = 0;
    m_req = 0; m_reqv = 0; m_qx = 0; m_qy = 0;
    sbq.delete();
  endtask

  task automatic model_frame();
    exp_t e;
    int tx, ty, nx, ny;
    e.eats = 0; e.etx = 0; e.ety = 0;
    if ((m_x % 16 == 0) && (m_y % 16 == 0)) begin
      tx = m_x / 16;
      ty = m_y / 16;
      if (m_reqv != 0 && m_req != m_dir && nbr(m_req, tx, ty, nx, ny)) begin
        m_qx = nx; m_qy = ny;
        if (!wall_at(nx, ny)) begin
          m_dir = m_req;
          m_mov = 1;
        end
      end
      if (nbr(m_dir, tx, ty, nx, ny)) begin
        m_qx = nx; m_qy = ny;
        m_mov = wall_at(nx, ny) ? 0 : 1;
      end else begin
        m_mov = 0;
      end
    end else if (m_reqv != 0 && m_req == ((m_dir + 2) % 4)) begin
      m_dir = m_req;
    end
    if (m_mov != 0) begin
      case (m_dir)
        0:       m_y = m_y - 1;
        1:       m_x = m_x + 1;
        2:       m_y = m_y + 1;
        default: m_x = m_x - 1;
      endcase
      if ((m_x % 16 == 0) && (m_y % 16 == 0)) begin
        e.eats = 1; e.etx = m_x / 16; e.ety = m_y / 16;
      end
    end
    e.x = m_x; e.y = m_y; e.dir = m_dir; e.mov = m_mov; e.qx = m_qx; e.qy = m_qy;
    sbq.push_back(e);
  endtask

  task automatic compare_frame(input int eats_seen);
    exp_t e;
    if (sbq.size() == 0) begin
      checkOutput("sb_empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    checkOutput("pacman_x", int'(pacman_x), e.x);
    checkOutput("pacman_y", int'(pacman_y), e.y);
    checkOutput("cur_dir", int'(cur_dir), e.dir);
    checkOutput("moving", int'(moving), e.mov);
    checkOutput("eat_count", eats_seen, e.eats);
    if (e.eats > 0) begin
      checkOutput("eat_tx", last_eat_tx, e.etx);
      checkOutput("eat_ty", last_eat_ty, e.ety);
    end
    checkOutput("query_tx", int'(query_tx), e.qx);
    checkOutput("query_ty", int'(query_ty), e.qy);
  endtask

  // One full frame: model prediction pushed, vsync pulse driven, result compared.
  task automatic applyStimulus();
    int eats_before;
    eats_before = eat_total;
    model_frame();
    @(negedge clk) frame_clk = 1'b1;
    repeat (8) @(negedge clk);
    frame_clk = 1'b0;
    repeat (8) @(negedge clk);
    compare_frame(eat_total - eats_before);
  endtask

  task automatic apply_key(input logic [7:0] k);
    @(negedge clk) keycode = k;
    if (key_dir(k) >= 0) begin
      m_req  = key_dir(k);
      m_reqv = 1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_walls();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        wall[r][c] = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_x"}, int'(pacman_x), 304);
    checkOutput({tag, "_y"}, int'(pacman_y), 368);
    checkOutput({tag, "_dir"}, int'(cur_dir), 3);
    checkOutput({tag, "_moving"}, int'(moving), 0);
    checkOutput({tag, "_eat"}, int'(eat_valid), 0);
    checkOutput({tag, "_qtx"}, int'(query_tx), 0);
    checkOutput({tag, "_qty"}, int'(query_ty), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    keycode = 8'h00;
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int eats_before;
    tests = 0; fails = 0; eat_total = 0; last_eat_tx = -1; last_eat_ty = -1;
    rst = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    clear_walls();

    do_reset();
    check_reset_values("reset");

    apply_key(8'h07);
    for (int i = 0; i < 16; i++) applyStimulus();

    // Mid-tile reversal: right at x=310, then A.
    do_reset();
    apply_key(8'h07);
    for (int i = 0; i < 6; i++) applyStimulus();
    apply_key(8'h04);
    applyStimulus();

    do_reset();
    wall[23][18] = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus();
    clear_walls();

    // Up request blocked at start tile, accepted once the tile above opens.
    do_reset();
    wall[22][19] = 1'b1;
    apply_key(8'h1A);
    for (int i = 0; i < 20; i++) applyStimulus();
    clear_walls();

    // Second vsync edge arrives while the FSM sits in FWD_W and is dropped.
    do_reset();
    apply_key(8'h1A);
    eats_before = eat_total;
    model_frame();
    @(negedge clk) frame_clk = 1'b1;
    @(negedge clk) frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    frame_clk = 1'b1;
    repeat (8) @(negedge clk);
    frame_clk = 1'b0;
    repeat (8) @(negedge clk);
    compare_frame(eat_total - eats_before);

    // Reset landing while the FSM is in TURN_W.
    do_reset();
    apply_key(8'h1A);
    @(negedge clk) frame_clk = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("turnw_reset");
    model_reset();
    repeat (4) @(negedge clk);
    applyStimulus();

    // Walk to the left edge of the grid and stop there.
    do_reset();
    for (int i = 0; i < 306; i++) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
